spi_minion: RTL

SPI mode-0 responder (minion) that exchanges one fixed-width word per chip-select frame with an off-chip SPI controller. It synchronizes the asynchronous `cs`, `sclk` and `mosi` pins into the system clock domain. It deserializes MOSI into a word offered on a val/rdy send interface, and serializes a word accepted on a val/rdy recv interface onto MISO. It sits between the chip pads and the on-chip SPI adapter/router logic.

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_sync.sv | 56 +++++
 rtl/spi_minion.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 minion.
// Pure declarations: no logic, no latency.
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_t;

  localparam int SYNC_STAGES = 2;

  // Shortest sclk high/low phase, and cs setup, in clk periods.
  localparam int MIN_PHASE = 4;

endpackage

// File: rtl/spi_sync.sv
// 1-bit pin synchronizer: SYNC_STAGES flops, then optional registered rise/fall strobes.
// Level out after SYNC_STAGES clk; strobes one clk later; no backpressure.
module spi_sync
  import spi_pkg::*;
#(
  parameter logic RST_VAL = 1'b0,
  parameter bit   EDGES   = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign dout = sync_q[SYNC_STAGES-1];

  generate
    if (EDGES) begin : g_edges
      logic dly_q;
      logic rise_q;
      logic fall_q;

      // dly_q resets to the idle level so releasing reset never fakes an edge.
      always_ff @(posedge clk) begin
        if (reset) begin
          dly_q  <= RST_VAL;
          rise_q <= 1'b0;
          fall_q <= 1'b0;
        end else begin
          dly_q  <= dout;
          rise_q <= dout & ~dly_q;
          fall_q <= ~dout & dly_q;
        end
      end

      assign rise = rise_q;
      assign fall = fall_q;
    end else begin : g_no_edges
      assign rise = 1'b0;
      assign fall = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/spi_minion.sv
// SPI mode-0 minion: one nbits word per cs frame, rx word to send_*, tx word from recv_*.
// Pin edge to strobe 3 clk, send_val 1 clk later; a held send slot drops the new frame with an overflow pulse.
module spi_minion
  import spi_pkg::*;
#(
  parameter int nbits = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             sclk,
  input  logic             mosi,
  output logic             miso,
  input  logic [nbits-1:0] recv_msg,
  input  logic             recv_val,
  output logic             recv_rdy,
  output logic [nbits-1:0] send_msg,
  output logic             send_val,
  input  logic             send_rdy,
  output logic             overflow,
  output logic             frame_err
);

  localparam int              CW       = $clog2(nbits + 2);
  localparam logic [CW-1:0]   CNT_FULL = CW'(nbits);
  localparam logic [CW-1:0]   CNT_SAT  = CW'(nbits + 1);

  logic unused_cs_level;
  logic unused_sclk_level;
  logic unused_mosi_rise;
  logic unused_mosi_fall;
  logic cs_rise;
  logic cs_fall;
  logic sclk_rise;
  logic sclk_fall;
  logic mosi_s;

  spi_sync #(.RST_VAL(1'b1), .EDGES(1'b1)) u_sync_cs (
    .clk   (clk),
    .reset (reset),
    .din   (cs),
    .dout  (unused_cs_level),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_sync #(.RST_VAL(1'b0), .EDGES(1'b1)) u_sync_sclk (
    .clk   (clk),
    .reset (reset),
    .din   (sclk),
    .dout  (unused_sclk_level),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync #(.RST_VAL(1'b0), .EDGES(1'b0)) u_sync_mosi (
    .clk   (clk),
    .reset (reset),
    .din   (mosi),
    .dout  (mosi_s),
    .rise  (unused_mosi_rise),
    .fall  (unused_mosi_fall)
  );

  spi_state_t       state;
  logic [nbits-1:0] tx_sr;
  logic [nbits-1:0] rx_sr;
  logic [CW-1:0]    cnt;
  logic             buf_full;
  logic [nbits-1:0] buf_msg;

  // Shift applied before frame evaluation, so a cs rise landing on the last sclk rise still counts it.
  logic [nbits-1:0] rx_nxt;
  logic [CW-1:0]    cnt_nxt;

  always_comb begin
    rx_nxt  = rx_sr;
    cnt_nxt = cnt;
    if (sclk_rise) begin
      rx_nxt = {rx_sr[nbits-2:0], mosi_s};
      if (cnt != CNT_SAT) begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  assign miso     = tx_sr[nbits-1];
  assign recv_rdy = ~buf_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tx_sr     <= '0;
      rx_sr     <= '0;
      cnt       <= '0;
      buf_full  <= 1'b0;
      buf_msg   <= '0;
      send_msg  <= '0;
      send_val  <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;

      if (send_val && send_rdy) begin
        send_val <= 1'b0;
      end

      if (recv_val && recv_rdy) begin
        buf_full <= 1'b1;
        buf_msg  <= recv_msg;
      end

      case (state)
        IDLE: begin
          if (cs_fall) begin
            if (buf_full) begin
              tx_sr    <= buf_msg;
              buf_full <= 1'b0;
            end else begin
              tx_sr <= '0;
            end
            cnt   <= '0;
            state <= ACTIVE;
          end
        end

        ACTIVE: begin
          rx_sr <= rx_nxt;
          cnt   <= cnt_nxt;
          if (sclk_fall) begin
            tx_sr <= {tx_sr[nbits-2:0], 1'b0};
          end
          if (cs_rise) begin
            state <= IDLE;
            tx_sr <= '0;
            if (cnt_nxt == CNT_FULL) begin
              if (!send_val || send_rdy) begin
                send_msg <= rx_nxt;
                send_val <= 1'b1;
              end else begin
                overflow <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
